// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, default result width and
// small helpers used by the ALU and by the result buffer.
package alu_pkg;

    // Default ALU result width
    parameter int ALU_DATA_W = 32;

    // Opcode encodings; every other 4-bit value is illegal
    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_XOR = 4'b0010,
        ALU_ADD = 4'b0011,
        ALU_SUB = 4'b0100
    } alu_op_e;

    // Event counters are 8 bits wide and stop at their maximum
    localparam int CNT_W = 8;

    // True for the five defined opcodes only
    function automatic logic is_legal_op(input logic [3:0] op);
        return (op == ALU_AND) || (op == ALU_OR) || (op == ALU_XOR) ||
               (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

    // Increment that holds at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/alu_result_buffer_if.sv
// Result bus between the ALU, the result buffer and its consumer.
//
// Handshake: the in_* side has no backpressure -- an entry is offered in
// every cycle in_valid is high and is either stored or dropped. On the
// out_* side an entry transfers on a rising edge where out_valid and
// out_ready are both high; out_valid never depends on out_ready, and the
// head fields stay stable while out_valid is high and no transfer occurs.
interface alu_result_buffer_if
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ovf;
    logic [3:0]        in_op;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_ovf;
    logic [3:0]        out_op;

    // Producer / consumer side (ALU plus downstream stage)
    modport master (
        output in_valid, in_data, in_ovf, in_op, out_ready,
        input  out_valid, out_data, out_ovf, out_op
    );

    // Buffer side
    modport slave (
        input  in_valid, in_data, in_ovf, in_op, out_ready,
        output out_valid, out_data, out_ovf, out_op
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO. DEPTH must be a power of two (>= 2) so the
// pointers wrap naturally. Storage is not reset; only pointers and count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // Qualify requests so a careless caller cannot over- or under-run
    always_comb begin
        pop_ok  = pop && !empty;
        push_ok = push && (!full || pop_ok);
    end

    // Pointer and occupancy update; a simultaneous push and pop keeps count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + {{(AW-1){1'b0}}, 1'b1};
            if (pop_ok)  rd_ptr <= rd_ptr + {{(AW-1){1'b0}}, 1'b1};
            case ({push_ok, pop_ok})
                2'b10:   count <= count + {{AW{1'b0}}, 1'b1};
                2'b01:   count <= count - {{AW{1'b0}}, 1'b1};
                default: count <= count;
            endcase
        end
    end

    // Entry storage, written only on an accepted push
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

    // Show-ahead read and status flags derived from the occupancy register
    always_comb begin
        rdata = mem[rd_ptr];
        full  = (count == (AW+1)'(DEPTH));
        empty = (count == '0);
    end

endmodule

// File: rtl/alu_result_buffer.sv
// Buffers ALU results for a consumer that may stall. Illegal-opcode results
// and results arriving while full (with no pop) are dropped and counted;
// accepted overflowed results set a sticky flag and an overflow counter.
module alu_result_buffer
    import alu_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = ALU_DATA_W,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_result_buffer_if.slave bus,
    input  logic             clr_sticky,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty,
    output logic             sticky_ovf,
    output logic [CNT_W-1:0] ovf_cnt,
    output logic [CNT_W-1:0] drop_cnt
);
    // Stored entry layout: {op, ovf, data}
    localparam int EW = DATA_W + 5;

    logic          legal;
    logic          pop;
    logic          push;
    logic          drop;
    logic [EW-1:0] wr_entry;
    logic [EW-1:0] head;

    // Accept/drop decision; a pop in the same cycle frees a slot when full
    always_comb begin
        legal    = is_legal_op(bus.in_op);
        pop      = !empty && bus.out_ready;
        push     = bus.in_valid && legal && (!full || pop);
        drop     = bus.in_valid && !push;
        wr_entry = {bus.in_op, bus.in_ovf, bus.in_data};
    end

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (wr_entry),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Head entry presented combinationally from storage
    always_comb begin
        bus.out_valid = !empty;
        bus.out_data  = head[DATA_W-1:0];
        bus.out_ovf   = head[DATA_W];
        bus.out_op    = head[DATA_W+4:DATA_W+1];
    end

    // Drop counter: saturates, reset wins over a same-cycle drop
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (drop) begin
            drop_cnt <= sat_inc(drop_cnt);
        end
    end

    // Overflow tracking: only stored entries count; an overflowed push
    // beats a same-cycle clear request
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_cnt    <= '0;
            sticky_ovf <= 1'b0;
        end else if (push && bus.in_ovf) begin
            ovf_cnt    <= sat_inc(ovf_cnt);
            sticky_ovf <= 1'b1;
        end else if (clr_sticky) begin
            sticky_ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed bench for alu_result_buffer: a vector table for the main
// flow plus hand-written sequences for full, drop-saturation and reset.
module tb_alu_result_buffer;
    localparam int DW = 32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr_sticky;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       sticky_ovf;
    logic [7:0] ovf_cnt;
    logic [7:0] drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] exp_q[$];

    alu_result_buffer_if #(.DATA_W(DW)) bus ();

    alu_result_buffer #(.DEPTH(4), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .clr_sticky (clr_sticky),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .sticky_ovf (sticky_ovf),
        .ovf_cnt    (ovf_cnt),
        .drop_cnt   (drop_cnt)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        vld;
        logic [31:0] data;
        logic        ovf;
        logic [3:0]  op;
        logic        rdy;
        logic        clr;
        logic        e_vld;
        logic        chk_head;
        logic [31:0] e_data;
        logic        e_hovf;
        logic [3:0]  e_op;
        logic [2:0]  e_cnt;
        logic [7:0]  e_drop;
        logic [7:0]  e_ovfc;
        logic        e_sticky;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: act=0x%0h req=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_ovf    = 1'b0;
        bus.in_op     = 4'h0;
        bus.out_ready = 1'b0;
        clr_sticky    = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    // One cycle of a push attempt; rdy drives out_ready in the same cycle
    task automatic drive_push(input logic [31:0] d, input logic [3:0] op,
                              input logic ovf, input logic rdy);
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_op     = op;
        bus.in_ovf    = ovf;
        bus.out_ready = rdy;
        tick();
        idle_inputs();
    endtask

    // Pop everything, comparing each head against the expected queue
    task automatic drain(input string nm);
        int guard = 0;
        bus.out_ready = 1'b1;
        while (bus.out_valid === 1'b1 && guard < 16) begin
            if (exp_q.size() == 0) chk({nm, "_extra"}, 64'(bus.out_valid), 64'(1'b0));
            else chk({nm, "_data"}, 64'(bus.out_data), 64'(exp_q.pop_front()));
            tick();
            guard++;
        end
        bus.out_ready = 1'b0;
        chk({nm, "_guard"}, 64'(guard < 16), 64'(1'b1));
        chk({nm, "_empty"}, 64'(empty), 64'(1'b1));
        chk({nm, "_left"}, 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        // Reset state
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_empty", 64'(empty), 64'(1));
        chk("rst_full", 64'(full), 64'(0));
        chk("rst_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_drop", 64'(drop_cnt), 64'(0));
        chk("rst_ovfc", 64'(ovf_cnt), 64'(0));
        chk("rst_sticky", 64'(sticky_ovf), 64'(0));
        rst_n = 1'b1;

        // Main flow table: expected values are those after the edge
        vecs[0]  = '{1'b1, 32'h5,         1'b0, 4'h3, 1'b0, 1'b0, 1'b1, 1'b1, 32'h5,         1'b0, 4'h3, 3'd1, 8'd0, 8'd0, 1'b0};
        vecs[1]  = '{1'b1, 32'h8000_0000, 1'b1, 4'h4, 1'b0, 1'b0, 1'b1, 1'b1, 32'h5,         1'b0, 4'h3, 3'd2, 8'd0, 8'd1, 1'b1};
        vecs[2]  = '{1'b1, 32'h7,         1'b1, 4'h3, 1'b0, 1'b1, 1'b1, 1'b1, 32'h5,         1'b0, 4'h3, 3'd3, 8'd0, 8'd2, 1'b1};
        vecs[3]  = '{1'b0, 32'h0,         1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h5,         1'b0, 4'h3, 3'd3, 8'd0, 8'd2, 1'b0};
        vecs[4]  = '{1'b0, 32'h0,         1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 1'b1, 4'h4, 3'd2, 8'd0, 8'd2, 1'b0};
        vecs[5]  = '{1'b1, 32'hA5,        1'b0, 4'h2, 1'b1, 1'b0, 1'b1, 1'b1, 32'h7,         1'b1, 4'h3, 3'd2, 8'd0, 8'd2, 1'b0};
        vecs[6]  = '{1'b1, 32'h123,       1'b1, 4'h7, 1'b0, 1'b0, 1'b1, 1'b1, 32'h7,         1'b1, 4'h3, 3'd2, 8'd1, 8'd2, 1'b0};
        vecs[7]  = '{1'b0, 32'h456,       1'b1, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 32'h7,         1'b1, 4'h3, 3'd2, 8'd1, 8'd2, 1'b0};
        vecs[8]  = '{1'b0, 32'h0,         1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hA5,        1'b0, 4'h2, 3'd1, 8'd1, 8'd2, 1'b0};
        vecs[9]  = '{1'b0, 32'h0,         1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 4'h0, 3'd0, 8'd1, 8'd2, 1'b0};
        vecs[10] = '{1'b1, 32'hFFFF_FFFF, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 4'h0, 3'd1, 8'd1, 8'd2, 1'b0};
        vecs[11] = '{1'b0, 32'h0,         1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 4'h0, 3'd0, 8'd1, 8'd2, 1'b0};

        for (int i = 0; i < 12; i++) begin
            bus.in_valid  = vecs[i].vld;
            bus.in_data   = vecs[i].data;
            bus.in_ovf    = vecs[i].ovf;
            bus.in_op     = vecs[i].op;
            bus.out_ready = vecs[i].rdy;
            clr_sticky    = vecs[i].clr;
            tick();
            idle_inputs();
            chk($sformatf("v%0d_valid", i), 64'(bus.out_valid), 64'(vecs[i].e_vld));
            chk($sformatf("v%0d_count", i), 64'(count), 64'(vecs[i].e_cnt));
            chk($sformatf("v%0d_empty", i), 64'(empty), 64'(vecs[i].e_cnt == 3'd0));
            chk($sformatf("v%0d_drop", i), 64'(drop_cnt), 64'(vecs[i].e_drop));
            chk($sformatf("v%0d_ovfc", i), 64'(ovf_cnt), 64'(vecs[i].e_ovfc));
            chk($sformatf("v%0d_sticky", i), 64'(sticky_ovf), 64'(vecs[i].e_sticky));
            if (vecs[i].chk_head) begin
                chk($sformatf("v%0d_data", i), 64'(bus.out_data), 64'(vecs[i].e_data));
                chk($sformatf("v%0d_hovf", i), 64'(bus.out_ovf), 64'(vecs[i].e_hovf));
                chk($sformatf("v%0d_op", i), 64'(bus.out_op), 64'(vecs[i].e_op));
            end
        end

        // Fill to full, overflow drop, in-order drain
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            drive_push(32'(k), 4'h1, 1'b0, 1'b0);
            exp_q.push_back(32'(k));
        end
        chk("fill_count", 64'(count), 64'(4));
        chk("fill_full", 64'(full), 64'(1));
        drive_push(32'd5, 4'h1, 1'b0, 1'b0);
        chk("full_drop", 64'(drop_cnt), 64'(1));
        chk("full_count", 64'(count), 64'(4));
        drain("fill");

        // Full with simultaneous pop: push is accepted, count holds
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            drive_push(32'(k), 4'h3, 1'b0, 1'b0);
            exp_q.push_back(32'(k));
        end
        chk("pp_head", 64'(bus.out_data), 64'(exp_q.pop_front()));
        drive_push(32'd9, 4'h3, 1'b0, 1'b1);
        exp_q.push_back(32'd9);
        chk("pp_count", 64'(count), 64'(4));
        chk("pp_drop", 64'(drop_cnt), 64'(0));
        chk("pp_full", 64'(full), 64'(1));
        drain("pp");

        // Illegal opcode drops and drop counter saturation
        do_reset();
        drive_push(32'h77, 4'b0111, 1'b1, 1'b0);
        chk("ill_drop1", 64'(drop_cnt), 64'(1));
        chk("ill_count", 64'(count), 64'(0));
        chk("ill_ovfc", 64'(ovf_cnt), 64'(0));
        chk("ill_sticky", 64'(sticky_ovf), 64'(0));
        for (int k = 0; k < 299; k++) drive_push(32'(k), 4'(5 + (k % 11)), 1'b0, 1'b0);
        chk("ill_sat", 64'(drop_cnt), 64'(255));
        chk("ill_empty", 64'(empty), 64'(1));

        // Reset mid-operation with in_valid high
        do_reset();
        drive_push(32'h11, 4'h0, 1'b1, 1'b0);
        drive_push(32'h22, 4'h1, 1'b0, 1'b0);
        drive_push(32'h33, 4'h2, 1'b0, 1'b0);
        drive_push(32'h44, 4'h9, 1'b0, 1'b0);
        chk("pre_count", 64'(count), 64'(3));
        chk("pre_ovfc", 64'(ovf_cnt), 64'(1));
        chk("pre_drop", 64'(drop_cnt), 64'(1));
        chk("pre_sticky", 64'(sticky_ovf), 64'(1));
        rst_n        = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h55;
        bus.in_op    = 4'h3;
        bus.in_ovf   = 1'b1;
        tick();
        rst_n = 1'b1;
        idle_inputs();
        chk("mrst_count", 64'(count), 64'(0));
        chk("mrst_empty", 64'(empty), 64'(1));
        chk("mrst_valid", 64'(bus.out_valid), 64'(0));
        chk("mrst_full", 64'(full), 64'(0));
        chk("mrst_drop", 64'(drop_cnt), 64'(0));
        chk("mrst_ovfc", 64'(ovf_cnt), 64'(0));
        chk("mrst_sticky", 64'(sticky_ovf), 64'(0));
        tick();
        chk("mrst_after", 64'(count), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_result_buffer.md
ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

Interface
REQ-001: Parameter DEPTH, default 4, result FIFO entries; SHALL be a power of two, at least 2.
REQ-002: Parameter DATA_W, default 32, result width.
REQ-003: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004: rst_n  input  1  reset, synchronous and active-low.
REQ-005: in_valid  input  1  ALU result present this cycle; the ALU has no backpressure.
REQ-006: in_data  input  DATA_W  ALU result (out).
REQ-007: in_ovf  input  1  ALU overflow flag for in_data.
REQ-008: in_op  input  4  opcode that produced the result.
REQ-009: out_valid  output  1  head entry available.
REQ-010: out_ready  input  1  consumer accepts the head entry.
REQ-011: out_data / out_ovf / out_op  output  DATA_W / 1 / 4  head entry fields.
REQ-012: count  output  clog2(DEPTH)+1  current occupancy.
REQ-013: full / empty  output  1 / 1  count==DEPTH / count==0.
REQ-014: sticky_ovf  output  1  set by any accepted overflowed result.
REQ-015: clr_sticky  input  1  clears sticky_ovf.
REQ-016: ovf_cnt / drop_cnt  output  8 / 8  accepted-overflow and dropped-result counters.

Function
REQ-017: Legal opcodes SHALL be 0000 AND, 0001 OR, 0010 XOR, 0011 ADD, 0100 SUB; any other in_op is illegal.
REQ-018: Pop SHALL occur when out_valid && out_ready.
REQ-019: Push SHALL occur when in_valid, in_op is legal, and (!full || pop).
REQ-020: in_valid with a legal op while full and no pop SHALL drop the result; in_valid with an illegal op SHALL always drop it.
REQ-021: Each dropped result SHALL increment drop_cnt, saturating at 255.
REQ-022: The FIFO SHALL be show-ahead: out_data/out_ovf/out_op reflect the head entry combinationally from storage, with out_valid = !empty.
REQ-023: A push at edge N SHALL make the entry visible after edge N; there is no same-cycle bypass when empty.
REQ-024: Simultaneous push and pop SHALL leave count unchanged, including when full.
REQ-025: Read and write pointers SHALL wrap modulo DEPTH.
REQ-026: Output fields while empty are don't-care but SHALL NOT cause X on out_valid.
REQ-027: Each pushed entry with in_ovf=1 SHALL set sticky_ovf and increment ovf_cnt (saturating at 255); dropped entries SHALL NOT affect either.
REQ-028: clr_sticky SHALL clear sticky_ovf next edge, except that a same-cycle overflowed push wins and sticky_ovf stays 1.
REQ-029: Entries SHALL be stored and delivered in order, unmodified.

Reset
REQ-030: With rst_n=0 at an edge: pointers, count and all counters SHALL go to 0, sticky_ovf to 0, out_valid to 0, full to 0, empty to 1; in_valid is ignored that cycle.
REQ-031: Reset mid-operation SHALL discard all stored entries; storage contents need no reset.

Structure
REQ-032: Opcode constants (ALU_AND..ALU_SUB) and DATA_W default SHALL live in shared package alu_pkg, used by the ALU and this block.
REQ-033: Storage and pointers SHALL be a sub-module sync_fifo (parameterised width/depth, push/pop/full/empty/count); legality, drop and overflow logic stay in alu_result_buffer.

Verification
REQ-034: After reset, push ADD 0x00000005 ovf=0, with out_ready=0 -> next cycle out_valid=1, out_data=0x5, count=1.
REQ-035: Push SUB 0x80000000 ovf=1, then pulse clr_sticky in the same cycle as a second overflowed push -> sticky_ovf stays 1, ovf_cnt=2; clr_sticky alone later -> 0.
REQ-036: Fill 4 entries 1..4 with out_ready=0, then push 5 -> drop_cnt=1, count=4; drain -> data 1,2,3,4 in order, then empty=1.
REQ-037: Full, push 9 with out_ready=1 the same cycle -> count stays 4, drop_cnt unchanged, 9 emerges last.
REQ-038: Push with in_op=0111 -> no entry, drop_cnt+1; 300 drops -> drop_cnt=255.
REQ-039: 3 entries held, assert rst_n=0 for one cycle with in_valid=1 -> count=0, empty=1, all counters 0.
